// File: rtl/miriscv_data_ram.sv
// Single-port data RAM responding on the core data bus (req/gnt, rvalid/rdata).
// Optional feature macro: DATA_RAM_ERR_EN (adds data_err_o, range-checks addresses).
module miriscv_data_ram #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o
`ifdef DATA_RAM_ERR_EN
    ,
    output logic        data_err_o
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Merge enabled byte lanes of new data over the old word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                res[8*n +: 8] = new_w[8*n +: 8];
            end else begin
                res[8*n +: 8] = old_w[8*n +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]   mem_q [DEPTH];
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   resp_q;
    logic          resp_err_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic          accept_s;
    logic          wr_en_s;
    logic [31:0]   rd_word_s;
    logic          unused_s;

    assign idx_s    = data_addr_i[AW+1:2];
    assign unused_s = ^{data_addr_i[1:0], data_addr_i[31:AW+2]};

`ifdef DATA_RAM_ERR_EN
    assign oor_s = |data_addr_i[31:AW+2];
`else
    assign oor_s = 1'b0;
`endif

    // Grant only in IDLE, and never while reset is asserted.
    assign data_gnt_o = arstn_i & data_req_i & (state_q == IDLE);
    assign accept_s   = data_gnt_o;
    assign wr_en_s    = accept_s & data_we_i & ~oor_s;

    // Word seen by a read at acceptance; out-of-range reads return zero.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (oor_s) begin
            rd_word_s = 32'h0000_0000;
        end else begin
            rd_word_s = mem_q[idx_s];
        end
    end

    // Storage array: byte-enabled write on the accept edge, never cleared.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[idx_s] <= be_merge(mem_q[idx_s], data_wdata_i, data_be_i);
        end
    end

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            resp_q     <= 32'h0000_0000;
            resp_err_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= 32'h0000_0000;
                    err_q    <= 1'b0;
                    if (accept_s) begin
                        resp_q     <= data_we_i ? 32'h0000_0000 : rd_word_s;
                        resp_err_q <= oor_s;
                        if (LATENCY == 1) begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= data_we_i ? 32'h0000_0000 : rd_word_s;
                            err_q    <= oor_s;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= resp_q;
                        err_q    <= resp_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                    rdata_q  <= 32'h0000_0000;
                    err_q    <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= 4'd0;
                    rvalid_q <= 1'b0;
                    rdata_q  <= 32'h0000_0000;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
`ifdef DATA_RAM_ERR_EN
    assign data_err_o    = err_q;
`else
    logic unused_err_s;
    assign unused_err_s = err_q ^ resp_err_q;
`endif

endmodule

// File: tb/tb_miriscv_data_ram.sv
// Randomized bench for miriscv_data_ram: LATENCY=1 and LATENCY=4 instances
// checked against an array-based memory model and per-cycle handshake rules.
module tb_miriscv_data_ram;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              arstn;
    logic [1:0]        req, we, gnt, rvalid, err;
    logic [1:0][3:0]   be;
    logic [1:0][31:0]  addr, wdata, rdata;

    int vecs = 0;
    int errs = 0;

    logic [31:0] ref_mem [2][DEPTH];
    logic [3:0]  known   [2][DEPTH];

    miriscv_data_ram #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .arstn_i(arstn),
        .data_req_i(req[0]), .data_we_i(we[0]), .data_be_i(be[0]),
        .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0])
`ifdef DATA_RAM_ERR_EN
        , .data_err_o(err[0])
`endif
    );

    miriscv_data_ram #(.DEPTH(DEPTH), .LATENCY(4)) u_dut4 (
        .clk_i(clk), .arstn_i(arstn),
        .data_req_i(req[1]), .data_we_i(we[1]), .data_be_i(be[1]),
        .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1])
`ifdef DATA_RAM_ERR_EN
        , .data_err_o(err[1])
`endif
    );

`ifndef DATA_RAM_ERR_EN
    assign err = 2'b00;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
`ifdef DATA_RAM_ERR_EN
        return (a[31:12] != 20'h0);
`else
        return (a[31:12] != a[31:12]);
`endif
    endfunction

    // Drive a request in an idle cycle, update the model, return at the accept edge.
    task automatic accept(input int k, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] er, output logic ee, output logic cmp);
        int idx;
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        #1;
        check_val("gnt_idle", {31'h0, gnt[k]}, 32'd1);
        check_val("rvalid_idle", {31'h0, rvalid[k]}, 32'd0);
        check_val("rdata_idle", rdata[k], 32'h0);
        idx = (a / 4) % DEPTH;
        ee  = out_of_range(a);
        if (w) begin
            er  = 32'h0;
            cmp = 1'b1;
            if (!ee) begin
                for (int n = 0; n < 4; n++) begin
                    if (b[n]) begin
                        ref_mem[k][idx][8*n +: 8] = d[8*n +: 8];
                        known[k][idx][n] = 1'b1;
                    end
                end
            end
        end else begin
            er  = ee ? 32'h0 : ref_mem[k][idx];
            cmp = ee || (known[k][idx] == 4'hF);
        end
        @(posedge clk);
    endtask

    // Check the wait/response cycles; junk request fields are held while busy.
    task automatic resp(input int k, input logic [31:0] er, input logic ee, input logic cmp);
        int lat;
        lat = lat_of(k);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                req[k] = 1'b1; we[k] = 1'($urandom); be[k] = 4'($urandom);
                addr[k] = $urandom; wdata[k] = $urandom;
            end else begin
                req[k] = 1'b0;
            end
            #1;
            check_val("gnt_busy", {31'h0, gnt[k]}, 32'd0);
            check_val("rvalid", {31'h0, rvalid[k]}, {31'h0, c == lat});
            check_val("err", {31'h0, err[k]}, {31'h0, (c == lat) && ee});
            if (c == lat && cmp) begin
                check_val("rdata", rdata[k], er);
            end
        end
    endtask

    task automatic txn(input int k, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] er;
        logic        ee, cmp;
        accept(k, w, b, a, d, er, ee, cmp);
        resp(k, er, ee, cmp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er, a;
        logic        ee, cmp;
        int          k;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                ref_mem[i][j] = 32'h0;
                known[i][j]   = 4'h0;
            end
        end
        arstn = 1'b0; req = 2'b11; we = 2'b00; be = '0; addr = '0; wdata = '0;

        // Reset held for 3 cycles with requests pending.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                check_val("rst_gnt", {31'h0, gnt[i]}, 32'd0);
                check_val("rst_rvalid", {31'h0, rvalid[i]}, 32'd0);
                check_val("rst_rdata", rdata[i], 32'h0);
                check_val("rst_err", {31'h0, err[i]}, 32'd0);
            end
        end
        @(negedge clk);
        arstn = 1'b1;
        #1;
        check_val("rel_gnt0", {31'h0, gnt[0]}, 32'd1);
        check_val("rel_gnt1", {31'h0, gnt[1]}, 32'd1);
        req = 2'b00;

        // Write/read and byte merge at LATENCY=1.
        txn(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0);
        txn(0, 1'b1, 4'h6, 32'h10, 32'h00AA_5500);
        txn(0, 1'b0, 4'h3, 32'h10, 32'h0);
        txn(0, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF);
        txn(0, 1'b0, 4'hF, 32'h12, 32'h0);

        // Out-of-range write: error strobe with the macro, aliasing without.
        txn(0, 1'b1, 4'hF, 32'h0, 32'h1122_3344);
        txn(0, 1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D);
        txn(0, 1'b0, 4'hF, 32'h0, 32'h0);
        txn(0, 1'b0, 4'hF, 32'h1000, 32'h0);

        // LATENCY=4 back-to-back.
        txn(1, 1'b1, 4'hF, 32'h20, 32'hA5A5_5A5A);
        txn(1, 1'b0, 4'h0, 32'h20, 32'h0);

        // Reset in WAIT: response dropped, write stays committed.
        accept(1, 1'b1, 4'hF, 32'h40, 32'h1234_5678, er, ee, cmp);
        @(negedge clk);
        req[1] = 1'b0;
        #1;
        check_val("abort_rvalid_t1", {31'h0, rvalid[1]}, 32'd0);
        @(negedge clk);
        arstn = 1'b0;
        req[1] = 1'b1;
        #1;
        check_val("abort_gnt_rst", {31'h0, gnt[1]}, 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        req[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check_val("abort_no_rvalid", {31'h0, rvalid[1]}, 32'd0);
        end
        txn(1, 1'b0, 4'h0, 32'h40, 32'h0);

        // Seed a small address pool, then random traffic on both instances.
        for (int i = 0; i < 8; i++) begin
            txn(0, 1'b1, 4'hF, i * 4, $urandom);
            txn(1, 1'b1, 4'hF, i * 4, $urandom);
        end
        for (int t = 0; t < 300; t++) begin
            k = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            txn(k, 1'($urandom), 4'($urandom), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
